// File: rtl/adc_pkg.sv
// Shared constants and helpers for the ADC sample averaging path.
package adc_pkg;

  localparam int unsigned ADC_WIDTH      = 8;
  localparam int unsigned DROP_CNT_WIDTH = 8;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } acc_state_e;

  // Sum of 2^log2_avg samples of width w needs log2_avg extra bits.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned log2_avg);
    return w + log2_avg;
  endfunction

endpackage

// File: rtl/adc_sample_averager_if.sv
// Conversion input, result handshake and status signals of the averager.
interface adc_sample_averager_if
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH = ADC_WIDTH
) ();

  logic                      in_valid;
  logic [WIDTH-1:0]          in_data;
  logic                      clear;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      overflow;
  logic [DROP_CNT_WIDTH-1:0] drop_count;

  modport master (
    output in_valid, in_data, clear, out_ready,
    input  out_valid, out_data, overflow, drop_count
  );

  modport slave (
    input  in_valid, in_data, clear, out_ready,
    output out_valid, out_data, overflow, drop_count
  );

endinterface

// File: rtl/sample_fifo.sv
// First-word-fall-through result FIFO; push while full is accepted only with a same-cycle pop.
module sample_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic             do_pop, do_push;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AddrW-1:0]] <= push_data;
        wr_ptr_q                   <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_sample_averager.sv
// Averages 2^LOG2_AVG ADC conversions, buffers results and tracks dropped results.
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH    = ADC_WIDTH,
  parameter int unsigned LOG2_AVG = 2,
  parameter int unsigned DEPTH    = 4
) (
  input logic                clk,
  input logic                rst,
  adc_sample_averager_if.slave bus
);

  localparam int unsigned AccW = acc_width(WIDTH, LOG2_AVG);
  localparam int unsigned CntW = (LOG2_AVG > 0) ? LOG2_AVG : 1;

  acc_state_e                state_q;
  logic [AccW-1:0]           acc_q;
  logic [AccW-1:0]           sum;
  logic [CntW-1:0]           cnt_q;
  logic                      last_sample;
  logic                      take;
  logic                      push;
  logic                      pop;
  logic                      drop;
  logic                      full;
  logic                      empty;
  logic [WIDTH-1:0]          result;
  logic [WIDTH-1:0]          head_data;
  logic [WIDTH-1:0]          hold_q;
  logic                      overflow_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

  assign sum         = acc_q + AccW'(bus.in_data);
  assign result      = sum[AccW-1:LOG2_AVG];
  // With LOG2_AVG=0 there is no counter and every sample is final.
  assign last_sample = (LOG2_AVG == 0) || (cnt_q == {CntW{1'b1}});
  assign take        = bus.in_valid & ~bus.clear;
  assign push        = take & last_sample;
  assign pop         = bus.out_ready & ~empty & ~bus.clear;
  assign drop        = push & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (bus.clear) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid && !last_sample) begin
            state_q <= StAccum;
            acc_q   <= AccW'(bus.in_data);
            cnt_q   <= CntW'(1);
          end
        end
        StAccum: begin
          if (bus.in_valid) begin
            if (last_sample) begin
              state_q <= StIdle;
              acc_q   <= '0;
              cnt_q   <= '0;
            end else begin
              acc_q <= sum;
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          acc_q   <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != {DROP_CNT_WIDTH{1'b1}}) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  // Remembers the last presented head so out_data is stable once the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (!empty) begin
      hold_q <= head_data;
    end
  end

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (result),
    .pop       (pop),
    .flush     (bus.clear),
    .full      (full),
    .empty     (empty),
    .head_data (head_data)
  );

  assign bus.out_valid  = ~empty;
  assign bus.out_data   = empty ? hold_q : head_data;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_cnt_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench: table of 4-sample averages plus backpressure, clear, reset and LOG2_AVG=0 cases.
module tb_adc_sample_averager;
  import adc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_sample_averager_if #(.WIDTH(8)) bus ();
  adc_sample_averager_if #(.WIDTH(8)) bus0 ();

  adc_sample_averager #(.WIDTH(8), .LOG2_AVG(2), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  adc_sample_averager #(.WIDTH(8), .LOG2_AVG(0), .DEPTH(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  typedef struct packed {
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] s3;
    logic [7:0] exp;
  } avg_vec_t;

  avg_vec_t vec [6];
  int total = 0;
  int bad   = 0;

  function automatic avg_vec_t mk(input logic [7:0] a, b, c, d, e);
    avg_vec_t v;
    v.s0 = a; v.s1 = b; v.s2 = c; v.s3 = d; v.exp = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] v);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic avg4(input logic [7:0] v);
    for (int k = 0; k < 4; k++) pulse(v);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid   = 1'b0; bus.in_data  = '0; bus.clear  = 1'b0; bus.out_ready  = 1'b0;
    bus0.in_valid  = 1'b0; bus0.in_data = '0; bus0.clear = 1'b0; bus0.out_ready = 1'b0;
    vec[0] = mk(10, 20, 30, 41, 25);
    vec[1] = mk(255, 255, 255, 255, 255);
    vec[2] = mk(0, 0, 0, 0, 0);
    vec[3] = mk(1, 2, 3, 5, 2);
    vec[4] = mk(200, 100, 50, 25, 93);
    vec[5] = mk(128, 128, 128, 127, 127);

    #12;
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_out_data", {24'd0, bus.out_data}, 0);
    check("rst_overflow", {31'd0, bus.overflow}, 0);
    check("rst_drop_count", {24'd0, bus.drop_count}, 0);
    tick();
    rst = 1'b0;

    // Table of averages, consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pulse(vec[i].s0);
      pulse(vec[i].s1);
      pulse(vec[i].s2);
      check($sformatf("vec%0d_early_valid", i), {31'd0, bus.out_valid}, 0);
      pulse(vec[i].s3);
      check($sformatf("vec%0d_valid", i), {31'd0, bus.out_valid}, 1);
      check($sformatf("vec%0d_data", i), {24'd0, bus.out_data}, {24'd0, vec[i].exp});
      tick();
      check($sformatf("vec%0d_valid_gone", i), {31'd0, bus.out_valid}, 0);
    end

    // Backpressure: fifth result dropped.
    do_reset();
    for (int k = 0; k < 5; k++) avg4(8'(100 + k));
    check("bp_overflow", {31'd0, bus.overflow}, 1);
    check("bp_drop_count", {24'd0, bus.drop_count}, 1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_valid%0d", k), {31'd0, bus.out_valid}, 1);
      check($sformatf("bp_data%0d", k), {24'd0, bus.out_data}, 100 + k);
      tick();
    end
    check("bp_empty", {31'd0, bus.out_valid}, 0);
    check("bp_hold_data", {24'd0, bus.out_data}, 103);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int k = 1; k <= 4; k++) avg4(8'(k));
    pulse(5); pulse(5); pulse(5);
    bus.out_ready = 1'b1;
    pulse(5);
    bus.out_ready = 1'b0;
    check("pp_drop_count", {24'd0, bus.drop_count}, 0);
    check("pp_overflow", {31'd0, bus.overflow}, 0);
    check("pp_head", {24'd0, bus.out_data}, 2);
    bus.out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("pp_data%0d", k), {24'd0, bus.out_data}, k);
      tick();
    end
    check("pp_empty", {31'd0, bus.out_valid}, 0);

    // clear mid-accumulation, with a sample in the clear cycle.
    do_reset();
    bus.out_ready = 1'b1;
    pulse(50); pulse(50);
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 200;
    tick();
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    avg4(8);
    check("clr_valid", {31'd0, bus.out_valid}, 1);
    check("clr_data", {24'd0, bus.out_data}, 8);
    tick();

    // clear while the FIFO holds data and overflow is set.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) avg4(8'(30 + k));
    pulse(9);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clrf_valid", {31'd0, bus.out_valid}, 0);
    check("clrf_overflow", {31'd0, bus.overflow}, 1);
    check("clrf_drop_count", {24'd0, bus.drop_count}, 1);
    check("clrf_hold", {24'd0, bus.out_data}, 30);
    bus.out_ready = 1'b1;
    avg4(12);
    check("clrf_next", {24'd0, bus.out_data}, 12);
    tick();

    // Asynchronous reset mid-average.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) avg4(8'(70 + k));
    pulse(1); pulse(2);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, bus.out_valid}, 0);
    check("arst_data", {24'd0, bus.out_data}, 0);
    check("arst_overflow", {31'd0, bus.overflow}, 0);
    check("arst_drop_count", {24'd0, bus.drop_count}, 0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    avg4(60);
    check("arst_fresh_valid", {31'd0, bus.out_valid}, 1);
    check("arst_fresh_data", {24'd0, bus.out_data}, 60);
    tick();

    // LOG2_AVG=0: each sample is a result.
    bus0.out_ready = 1'b1;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 7;
    tick();
    check("l0_valid0", {31'd0, bus0.out_valid}, 1);
    check("l0_data0", {24'd0, bus0.out_data}, 7);
    bus0.in_data = 200;
    tick();
    bus0.in_valid = 1'b0;
    check("l0_valid1", {31'd0, bus0.out_valid}, 1);
    check("l0_data1", {24'd0, bus0.out_data}, 200);
    tick();
    check("l0_empty", {31'd0, bus0.out_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
